// File: rtl/iu_pkg.sv
// Shared definitions for the instruction-fetch unit: default sizes,
// fetch FSM state encoding and the instruction-word type.
package iu_pkg;

  localparam int unsigned DATA_W_DEF = 13;
  localparam int unsigned DEPTH_DEF  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  typedef logic [DATA_W_DEF-1:0] instr_word_t;

endpackage

// File: rtl/imem_fetch_array.sv
// Instruction storage: DEPTH x DATA_W words, synchronous write and
// registered read. Contents survive reset; only the read register clears.
module imem_array
  import iu_pkg::*;
#(
  parameter  int unsigned DATA_W = DATA_W_DEF,
  parameter  int unsigned DEPTH  = DEPTH_DEF,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register holds its value when re_i is low so the presented word stays stable.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_fetch.sv
// Instruction fetch unit: program-load port, PC/FSM and a valid/ready
// output stream fed from a registered-read instruction memory.
module imem_fetch
  import iu_pkg::*;
#(
  parameter  int unsigned DATA_W = DATA_W_DEF,
  parameter  int unsigned DEPTH  = DEPTH_DEF,
  parameter  int unsigned WRAP   = 0,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_err,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(DEPTH - 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;
  logic              load_err_q, load_err_d;

  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] pc_inc;
  logic              xfer;

  assign xfer   = valid_q && instr_ready;
  assign pc_inc = pc_q + ADDR_W'(1);

  // pc_q always names the word being (or about to be) presented, so it doubles as instr_pc.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    halted_d   = halted_q;
    load_err_d = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = pc_q;

    case (state_q)
      ST_IDLE, ST_HALT: begin
        wr_en = load_en && !reset;
        if (start) begin
          state_d  = ST_FETCH;
          pc_d     = start_addr;
          valid_d  = 1'b1;
          halted_d = 1'b0;
          rd_en    = 1'b1;
          rd_addr  = start_addr;
        end
      end
      ST_FETCH: begin
        load_err_d = load_en;
        if (jump_en) begin
          pc_d    = jump_addr;
          valid_d = 1'b0;
        end else if (xfer) begin
          if (pc_q == LAST_PC && WRAP == 0) begin
            state_d  = ST_HALT;
            valid_d  = 1'b0;
            halted_d = 1'b1;
          end else begin
            pc_d    = pc_inc;
            valid_d = 1'b1;
            rd_en   = 1'b1;
            rd_addr = pc_inc;
          end
        end else if (!valid_q) begin
          // Refill after a jump bubble.
          valid_d = 1'b1;
          rd_en   = 1'b1;
          rd_addr = pc_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
      load_err_q <= load_err_d;
    end
  end

  imem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk_i   (clk),
    .clr_i   (reset),
    .we_i    (wr_en),
    .waddr_i (load_addr),
    .wdata_i (load_data),
    .re_i    (rd_en),
    .raddr_i (rd_addr),
    .rdata_o (instr)
  );

  assign instr_pc    = pc_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;
  assign load_err    = load_err_q;

endmodule

// File: tb/tb_imem_fetch.sv
// Directed bench for imem_fetch: one halting and one wrapping instance
// driven from shared stimulus, checked against hand-computed values.
module tb_imem_fetch;

  localparam int unsigned DW = 13;
  localparam int unsigned DP = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic          start;
  logic [AW-1:0] start_addr;
  logic          jump_en;
  logic [AW-1:0] jump_addr;
  logic          instr_ready;

  logic          load_err,    load_err_w;
  logic [DW-1:0] instr,       instr_w;
  logic [AW-1:0] instr_pc,    instr_pc_w;
  logic          instr_valid, instr_valid_w;
  logic          halted,      halted_w;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  imem_fetch #(.DATA_W(DW), .DEPTH(DP), .WRAP(0)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .load_err(load_err), .start(start),
    .start_addr(start_addr), .jump_en(jump_en), .jump_addr(jump_addr),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .halted(halted)
  );

  imem_fetch #(.DATA_W(DW), .DEPTH(DP), .WRAP(1)) dut_w (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .load_err(load_err_w), .start(start),
    .start_addr(start_addr), .jump_en(jump_en), .jump_addr(jump_addr),
    .instr(instr_w), .instr_pc(instr_pc_w), .instr_valid(instr_valid_w),
    .instr_ready(instr_ready), .halted(halted_w)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the WRAP=0 instance's presented word.
  task automatic expect_word(input string tag, input int unsigned pc);
    check({tag, " valid"}, 32'(instr_valid), 32'd1);
    check({tag, " pc"},    32'(instr_pc),    32'(pc));
    check({tag, " instr"}, 32'(instr),       32'(pc + 1));
  endtask

  initial begin
    reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; start_addr = '0; jump_en = 1'b0; jump_addr = '0;
    instr_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst valid",    32'(instr_valid), 32'd0);
    check("rst instr",    32'(instr),       32'd0);
    check("rst pc",       32'(instr_pc),    32'd0);
    check("rst halted",   32'(halted),      32'd0);
    check("rst load_err", 32'(load_err),    32'd0);

    // Program: mem[i] = i + 1 in IDLE.
    for (int i = 0; i < int'(DP); i++) begin
      load_en = 1'b1; load_addr = AW'(i); load_data = DW'(i + 1);
      tick();
    end
    load_en = 1'b0;
    check("idle load no err", 32'(load_err), 32'd0);

    // Back-to-back stream from 0.
    start = 1'b1; start_addr = '0; instr_ready = 1'b1;
    tick();
    start = 1'b0;
    expect_word("b2b 0", 0);
    tick(); expect_word("b2b 1", 1);
    tick(); expect_word("b2b 2", 2);
    tick(); expect_word("b2b 3", 3);

    // Stall on addr 2 for three cycles.
    jump_en = 1'b1; jump_addr = 5'd2;
    tick();
    jump_en = 1'b0; instr_ready = 1'b0;
    check("jmp2 bubble", 32'(instr_valid), 32'd0);
    tick(); expect_word("stall a", 2);
    tick(); expect_word("stall b", 2);
    tick(); expect_word("stall c", 2);
    instr_ready = 1'b1;
    tick(); expect_word("after stall", 3);

    // Jump while presenting addr 1.
    jump_en = 1'b1; jump_addr = 5'd1;
    tick();
    jump_en = 1'b0;
    tick(); expect_word("at 1", 1);
    jump_en = 1'b1; jump_addr = 5'd5;
    tick();
    jump_en = 1'b0;
    check("jmp5 bubble", 32'(instr_valid), 32'd0);
    tick(); expect_word("jmp5 target", 5);
    tick(); expect_word("jmp5 next", 6);

    // Load attempt in FETCH is rejected.
    load_en = 1'b1; load_addr = '0; load_data = 13'h1FFF;
    tick();
    load_en = 1'b0;
    check("fetch load_err", 32'(load_err), 32'd1);
    tick();
    check("load_err pulse", 32'(load_err), 32'd0);

    // Reset mid-fetch.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst valid",  32'(instr_valid), 32'd0);
    check("midrst instr",  32'(instr),       32'd0);
    check("midrst halted", 32'(halted),      32'd0);
    jump_en = 1'b1; jump_addr = 5'd9;
    tick();
    jump_en = 1'b0;
    check("idle jump ignored", 32'(instr_valid), 32'd0);
    start = 1'b1; start_addr = '0;
    tick();
    start = 1'b0;
    expect_word("mem0 kept", 0);

    // End of memory: halt vs wrap.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b1; start_addr = 5'd30;
    tick();
    start = 1'b0;
    expect_word("end 30", 30);
    check("wrap 30 pc", 32'(instr_pc_w), 32'd30);
    tick();
    expect_word("end 31", 31);
    check("wrap 31 pc", 32'(instr_pc_w), 32'd31);
    tick();
    check("halt valid",   32'(instr_valid),   32'd0);
    check("halt halted",  32'(halted),        32'd1);
    check("wrap0 valid",  32'(instr_valid_w), 32'd1);
    check("wrap0 pc",     32'(instr_pc_w),    32'd0);
    check("wrap0 instr",  32'(instr_w),       32'd1);
    check("wrap halted",  32'(halted_w),      32'd0);
    tick();
    check("halt stays",   32'(halted),        32'd1);
    check("halt nvalid",  32'(instr_valid),   32'd0);
    check("wrap1 pc",     32'(instr_pc_w),    32'd1);
    check("wrap1 instr",  32'(instr_w),       32'd2);

    // Restart from HALT.
    start = 1'b1; start_addr = 5'd4;
    tick();
    start = 1'b0;
    expect_word("restart", 4);
    check("restart halted", 32'(halted), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
